// File: rtl/dpram_rd_pkg.sv
// Shared definitions for the dual-port RAM stream reader: FSM encoding and parameter legality check.
package dpram_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Buffer must absorb every read that can still be in the RAM pipe, and be a power of two.
   function automatic bit cfg_ok(input int unsigned n_delay, input int unsigned fifo_depth);
      return (n_delay >= 1) && (fifo_depth >= n_delay + 1) &&
             ((fifo_depth & (fifo_depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small flop-based FIFO with registered occupancy count and registered not-empty flag.
module stream_fifo #(
   parameter int unsigned W     = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             wr_en,
   input  logic [W-1:0]                     wr_data,
   input  logic                             rd_en,
   output logic                             rd_valid,
   output logic [W-1:0]                     rd_data,
   output logic [$clog2(DEPTH):0]           count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic          push_c, pop_c;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      push_c   = wr_en && (count_q != CW'(DEPTH));
      pop_c    = rd_en && valid_q;
      if (push_c) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   assign rd_valid = valid_q;
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst reader: streams len words from a fixed-latency RAM read port into a ready/valid output,
// issuing reads only when the output buffer has room for everything already in flight.
module dpram_stream_reader
   import dpram_rd_pkg::*;
#(
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 14,
   parameter int unsigned N_DELAY    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          ram_enb,
   output logic [AW-1:0] ram_addrb,
   input  logic [DW-1:0] ram_dob,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last
);

   localparam int unsigned LW  = AW + 1;
   localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 2;

   if (!cfg_ok(N_DELAY, FIFO_DEPTH)) begin : g_bad_cfg
      $error("dpram_stream_reader: FIFO_DEPTH must be a power of two >= N_DELAY+1");
   end

   rd_state_e          state_q, state_d;
   logic [AW-1:0]      base_q, base_d;
   logic [LW-1:0]      len_q, len_d;
   logic [LW-1:0]      issued_q, issued_d;
   logic [LW-1:0]      wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic               issue_q, issue_d;
   logic [N_DELAY-1:0] tag_q, tag_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               enb_q, enb_d;

   logic [CW-1:0]      outstanding_c;
   logic               fifo_wr_c, wr_last_c, beat_c;
   logic [FCW-1:0]     fifo_count;
   logic               fifo_valid;
   logic [DW:0]        fifo_rd_data;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      issued_d = issued_q;
      wr_cnt_d = wr_cnt_q;
      addr_d   = addr_q;
      issue_d  = 1'b0;
      done_d   = 1'b0;

      // issue_q marks the cycle the address is on the port; tag stage k is k+1 cycles later.
      tag_d[0]      = issue_q;
      outstanding_c = CW'(issue_q) + CW'(fifo_count);
      for (int unsigned i = 0; i < N_DELAY; i++) begin
         outstanding_c = outstanding_c + CW'(tag_q[i]);
         if (i > 0) tag_d[i] = tag_q[i-1];
      end

      fifo_wr_c = tag_q[N_DELAY-1];
      wr_last_c = (wr_cnt_q == len_q - LW'(1));
      beat_c    = fifo_valid && m_ready;
      if (fifo_wr_c) wr_cnt_d = wr_cnt_q + LW'(1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  base_d   = base_addr;
                  len_d    = len;
                  issued_d = '0;
                  wr_cnt_d = '0;
                  state_d  = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (issued_q == len_q) begin
               state_d = ST_DRAIN;
            end else if (outstanding_c < CW'(FIFO_DEPTH)) begin
               issue_d  = 1'b1;
               addr_d   = base_q + AW'(issued_q);
               issued_d = issued_q + LW'(1);
            end
         end
         ST_DRAIN: begin
            if (beat_c && fifo_rd_data[DW]) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      enb_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         issued_q <= '0;
         wr_cnt_q <= '0;
         addr_q   <= '0;
         issue_q  <= 1'b0;
         tag_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         enb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         wr_cnt_q <= wr_cnt_d;
         addr_q   <= addr_d;
         issue_q  <= issue_d;
         tag_q    <= tag_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         enb_q    <= enb_d;
      end
   end

   stream_fifo #(
      .W     (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en    (fifo_wr_c),
      .wr_data  ({wr_last_c, ram_dob}),
      .rd_en    (m_ready),
      .rd_valid (fifo_valid),
      .rd_data  (fifo_rd_data),
      .count    (fifo_count)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign ram_enb   = enb_q;
   assign ram_addrb = addr_q;
   assign m_valid   = fifo_valid;
   assign m_data    = fifo_rd_data[DW-1:0];
   assign m_last    = fifo_rd_data[DW];

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench: stimulus queues expected beats from an address-hash RAM model, monitors compare.
module tb_dpram_stream_reader;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 14;
   localparam int unsigned LW    = AW + 1;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A00_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instance A: N_DELAY=1 ----------------
   logic          rstn_a = 1'b0, st_a = 1'b0, ready_a = 1'b1;
   logic [AW-1:0] base_a = '0;
   logic [LW-1:0] len_a = '0;
   logic          busy_a, done_a, enb_a, valid_a, last_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] dob_a, data_a;
   logic [DW-1:0] pipe_a [1];

   dpram_stream_reader #(.DW(DW), .AW(AW), .N_DELAY(1), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rstn(rstn_a), .start(st_a), .base_addr(base_a), .len(len_a),
      .busy(busy_a), .done(done_a), .ram_enb(enb_a), .ram_addrb(addr_a), .ram_dob(dob_a),
      .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a), .m_last(last_a));

   always @(posedge clk) if (enb_a) pipe_a[0] <= memf(addr_a);
   assign dob_a = pipe_a[0];

   beat_t         exp_q[$];
   int            hs_cyc[$];
   logic [AW-1:0] addr_log[$];
   logic          mb = 1'b0, done_due = 1'b0, zero_now = 1'b0, accept_now = 1'b0;
   int            issued_a = 0, popped_a = 0, words_a = 0, start_cyc = 0;
   logic [AW-1:0] seen_addr_a = '0, last_addr_model = '0;
   int            rmode = 0;

   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       ready_a = 1'b1;
         1:       ready_a = ~ready_a;
         default: ready_a = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (rstn_a) begin
         chk("done", done_a, done_due);
         chk("busy", busy_a, mb);
         chk("ram_enb", enb_a, mb);
         if (enb_a && addr_a != seen_addr_a) begin
            issued_a++;
            seen_addr_a = addr_a;
            addr_log.push_back(addr_a);
         end
         total++;
         if (issued_a - popped_a > int'(DEPTH)) begin
            bad++;
            $display("FAIL credit: outstanding %0d exceeds %0d", issued_a - popped_a, DEPTH);
         end
         done_due = 1'b0;
         if (valid_a) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", valid_a, 1'b0);
            end else begin
               chk("m_data", data_a, exp_q[0].data);
               chk("m_last", last_a, exp_q[0].last);
               if (ready_a) begin
                  hs_cyc.push_back(cyc);
                  popped_a++;
                  if (exp_q[0].last) begin
                     mb       = 1'b0;
                     done_due = 1'b1;
                  end
                  void'(exp_q.pop_front());
               end
            end
         end
         if (accept_now) begin mb = 1'b1; accept_now = 1'b0; end
         if (zero_now)   begin done_due = 1'b1; zero_now = 1'b0; end
      end
   end

   // Called at posedge+1; holds start for exactly this cycle.
   task automatic do_start_a(input logic [AW-1:0] b_in, input logic [LW-1:0] n);
      logic [AW-1:0] b;
      b = b_in;
      if (!mb && n != '0 && b == last_addr_model) b = b + AW'(1);
      st_a = 1'b1; base_a = b; len_a = n;
      start_cyc = cyc;
      if (!mb) begin
         if (n == '0) begin
            zero_now = 1'b1;
         end else begin
            accept_now = 1'b1;
            for (int i = 0; i < int'(n); i++) begin
               exp_q.push_back(beat_t'{memf(AW'(b + AW'(i))), (i == int'(n) - 1)});
            end
            words_a += int'(n);
            last_addr_model = AW'(b + AW'(n - LW'(1)));
         end
      end
      @(posedge clk); #1;
      st_a = 1'b0;
   endtask

   task automatic wait_idle_a(input int budget);
      for (int c = 0; c < budget; c++) begin
         if (!mb && !accept_now && exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("idle_timeout", {mb, 31'(exp_q.size())}, 0);
      chk("issue_count", issued_a, words_a);
   endtask

   task automatic reset_a();
      rstn_a = 1'b0;
      #1;
      chk("rst_flags", {busy_a, done_a, enb_a, valid_a, last_a}, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_data", data_a, 0);
      exp_q.delete();
      mb = 1'b0; done_due = 1'b0; accept_now = 1'b0; zero_now = 1'b0;
      issued_a = 0; popped_a = 0; words_a = 0;
      seen_addr_a = '0; last_addr_model = '0;
      repeat (2) @(posedge clk);
      #1 rstn_a = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- instance B: N_DELAY=3 ----------------
   logic          rstn_b = 1'b0, st_b = 1'b0, ready_b = 1'b0;
   logic [AW-1:0] base_b = '0;
   logic [LW-1:0] len_b = '0;
   logic          busy_b, done_b, enb_b, valid_b, last_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] dob_b, data_b;
   logic [DW-1:0] pipe_b [3];

   dpram_stream_reader #(.DW(DW), .AW(AW), .N_DELAY(3), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk(clk), .rstn(rstn_b), .start(st_b), .base_addr(base_b), .len(len_b),
      .busy(busy_b), .done(done_b), .ram_enb(enb_b), .ram_addrb(addr_b), .ram_dob(dob_b),
      .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b), .m_last(last_b));

   always @(posedge clk) begin
      if (enb_b) begin
         pipe_b[0] <= memf(addr_b);
         pipe_b[1] <= pipe_b[0];
         pipe_b[2] <= pipe_b[1];
      end
   end
   assign dob_b = pipe_b[2];

   beat_t         exp_b[$];
   int            issued_b = 0, done_cnt_b = 0;
   logic [AW-1:0] seen_b = '0;

   always @(negedge clk) begin
      if (rstn_b) begin
         if (enb_b && addr_b != seen_b) begin
            issued_b++;
            seen_b = addr_b;
         end
         if (done_b) done_cnt_b++;
         if (valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
               chk("b_spurious", valid_b, 1'b0);
            end else begin
               chk("b_data", data_b, exp_b[0].data);
               chk("b_last", last_b, exp_b[0].last);
               void'(exp_b.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] wrap_exp [4];
      logic [AW-1:0] b;
      int            p0;
      int            s;
      wrap_exp = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

      #1;
      chk("rst_flags", {busy_a, done_a, enb_a, valid_a, last_a}, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_data", data_a, 0);
      repeat (3) @(posedge clk);
      #1 rstn_a = 1'b1; rstn_b = 1'b1;
      @(posedge clk); #1;

      // Four words back to back, first beat N_DELAY+1 after first issue.
      hs_cyc.delete();
      do_start_a(14'h0010, LW'(4));
      s = start_cyc;
      wait_idle_a(100);
      chk("lat_beats", hs_cyc.size(), 4);
      foreach (hs_cyc[i]) chk("lat_timing", hs_cyc[i] - s, 4 + i);

      // Stalling consumer.
      rmode = 1;
      do_start_a(14'h0123, LW'(8));
      wait_idle_a(200);

      // Address wrap.
      rmode = 0;
      addr_log.delete();
      do_start_a(14'h3FFE, LW'(4));
      wait_idle_a(100);
      chk("wrap_n", addr_log.size(), 4);
      foreach (addr_log[i]) if (i < 4) chk("wrap_addr", addr_log[i], wrap_exp[i]);

      // Empty burst, start in the done cycle, start while busy.
      do_start_a(14'h0200, LW'(0));
      do_start_a(14'h0200, LW'(5));
      do_start_a(14'h0333, LW'(3));
      wait_idle_a(100);

      // Whole address space.
      do_start_a(14'h2000, LW'(1 << AW));
      wait_idle_a(17000);

      // Reset in the middle of a burst.
      p0 = popped_a;
      do_start_a(14'h0777, LW'(8));
      for (int c = 0; c < 100 && popped_a - p0 < 3; c++) begin
         @(posedge clk); #1;
      end
      chk("beat3_reached", popped_a - p0, 3);
      reset_a();
      do_start_a(14'h0055, LW'(2));
      wait_idle_a(100);

      // Randomised bursts and consumer behaviour.
      for (int k = 0; k < 30; k++) begin
         rmode = $urandom_range(0, 2);
         b = AW'($urandom);
         do_start_a(b, LW'($urandom_range(0, 24)));
         if ($urandom_range(0, 3) == 0) do_start_a(AW'($urandom), LW'($urandom_range(1, 9)));
         wait_idle_a(600);
      end

      // Deep RAM latency with a stalled consumer.
      st_b = 1'b1; base_b = 14'h0100; len_b = LW'(6);
      for (int i = 0; i < 6; i++) exp_b.push_back(beat_t'{memf(AW'(14'h0100 + i)), (i == 5)});
      @(posedge clk); #1;
      st_b = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("b_issued_stalled", issued_b, 4);
      ready_b = 1'b1;
      for (int c = 0; c < 60 && exp_b.size() != 0; c++) begin
         @(posedge clk); #1;
      end
      chk("b_words_left", exp_b.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("b_issued_total", issued_b, 6);
      chk("b_done_pulses", done_cnt_b, 1);
      chk("b_busy_end", busy_b, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpram_stream_reader.md
DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

Interface
REQ-001 SHALL have parameter DW, default 32, RAM data word width.
REQ-002 SHALL have parameter AW, default 14, RAM address width.
REQ-003 SHALL have parameter N_DELAY, default 1, RAM read latency in cycles (>=1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >= N_DELAY+1).
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a burst read.
REQ-008 base_addr  input  AW  first word address, sampled with start.
REQ-009 len  input  AW+1  word count, sampled with start; 0 = empty burst.
REQ-010 busy  output  1  high while a burst is in progress.
REQ-011 done  output  1  one-cycle pulse at burst completion.
REQ-012 ram_enb  output  1  RAM read-port enable.
REQ-013 ram_addrb  output  AW  RAM read address.
REQ-014 ram_dob  input  DW  RAM read data, valid N_DELAY cycles after issue.
REQ-015 m_valid  output  1  output word available.
REQ-016 m_ready  input  1  consumer accepts word.
REQ-017 m_data  output  DW  output word.
REQ-018 m_last  output  1  marks final word of burst.

Function
REQ-019 FSM states SHALL be IDLE, READ, DRAIN; busy = (state != IDLE).
REQ-020 In IDLE, start with len>0 SHALL latch base_addr/len and enter READ next cycle; start with len==0 SHALL pulse done next cycle and remain IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 ram_enb SHALL be high every cycle in READ and DRAIN, low in IDLE, so enb-gated RAM delay chains free-run.
REQ-023 A read SHALL be issued in a cycle when issued_cnt < len and (in_flight + fifo_count) < FIFO_DEPTH; ram_addrb SHALL equal base_addr + issued_cnt that cycle, modulo 2^AW.
REQ-024 When no read is issued, ram_addrb SHALL hold its last value.
REQ-025 A N_DELAY-stage tag shift register SHALL mark issued cycles; ram_dob SHALL be written into the FIFO exactly when the tag exits, never dropped (guaranteed by the credit rule of REQ-023).
REQ-026 READ SHALL go to DRAIN in the cycle after the last issue; DRAIN SHALL go to IDLE on the m_valid&&m_ready beat with m_last.
REQ-027 done SHALL pulse in the cycle following the last handshake, coincident with busy low; start in that cycle SHALL be accepted.
REQ-028 m_valid = FIFO not empty; m_data/m_last SHALL stay stable while m_valid && !m_ready.
REQ-029 m_last SHALL be high only on beat len-1; with m_ready held high, throughput SHALL be one word per cycle after initial latency N_DELAY+1 from first issue.
REQ-030 Simultaneous FIFO write and read SHALL keep count unchanged; len = 2^AW SHALL read every address once, wrapping.

Reset
REQ-031 rstn low SHALL asynchronously force state IDLE, busy/done/ram_enb/m_valid/m_last 0, ram_addrb/m_data 0, all counters, tags and FIFO pointers 0.
REQ-032 Reset mid-burst SHALL discard in-flight reads and buffered words; no done pulse.

Structure
REQ-033 FSM state encoding and the FIFO_DEPTH >= N_DELAY+1 constraint check SHALL live in shared package dpram_rd_pkg.
REQ-034 Output buffer SHALL be one sub-module, stream_fifo (DW x FIFO_DEPTH, registered count).

Verification
REQ-035 base=0x10, len=4, m_ready=1, N_DELAY=1 -> m_data = ram[0x10..0x13] on 4 consecutive cycles, m_last on 4th, done one cycle later.
REQ-036 len=8, m_ready toggling 1/0 each cycle -> 8 words in order, data stable while stalled, no loss, in_flight+count never exceeds 4.
REQ-037 N_DELAY=3, FIFO_DEPTH=4, len=6, m_ready=0 for 10 cycles then 1 -> exactly 4 reads issued before release, all 6 words correct afterwards.
REQ-038 base=2^AW-2, len=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 (AW=14).
REQ-039 len=0 -> done one cycle after start, busy stays 0, no m_valid; start during busy ignored.
REQ-040 rstn low at beat 3 of len=8 -> all outputs 0 immediately; new start len=2 afterwards yields only its own 2 words.
